// File: rtl/dmem_arbiter_pkg.sv
// Shared types, FSM encoding and acceptance decode for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;
  typedef logic [3:0]  be_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } dmem_arb_state_t;

  localparam addr_t WORD_ADDR_MASK = 32'hFFFF_FFFC;

  // State entered from IDLE when a request is accepted. An empty store (be=0)
  // uses the WR slot with the write suppressed, so it completes at T+2 like a full store.
  function automatic dmem_arb_state_t accept_state(input logic we, input be_t be);
    if (!we)
      return ST_RD;
    if (be == 4'hF || be == 4'h0)
      return ST_WR;
    return ST_RMW_RD;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-side signal bundle of the data-memory arbiter.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic  i_req_valid_0, i_req_valid_1;
  logic  o_req_ready_0, o_req_ready_1;
  logic  i_req_we_0,    i_req_we_1;
  be_t   i_req_be_0,    i_req_be_1;
  addr_t i_req_addr_0,  i_req_addr_1;
  data_t i_req_wd_0,    i_req_wd_1;
  logic  o_rsp_valid_0, o_rsp_valid_1;
  data_t o_rsp_rd_0,    o_rsp_rd_1;

  addr_t o_mem_Addr;
  data_t o_mem_Wd;
  logic  o_mem_Wen;
  logic  o_mem_Ren;
  data_t i_mem_Rd;

  // The arbiter is the slave of both requesters and drives the memory.
  modport slave (
    input  i_req_valid_0, i_req_valid_1, i_req_we_0, i_req_we_1,
    input  i_req_be_0, i_req_be_1, i_req_addr_0, i_req_addr_1,
    input  i_req_wd_0, i_req_wd_1, i_mem_Rd,
    output o_req_ready_0, o_req_ready_1, o_rsp_valid_0, o_rsp_valid_1,
    output o_rsp_rd_0, o_rsp_rd_1, o_mem_Addr, o_mem_Wd, o_mem_Wen, o_mem_Ren
  );

  modport master (
    output i_req_valid_0, i_req_valid_1, i_req_we_0, i_req_we_1,
    output i_req_be_0, i_req_be_1, i_req_addr_0, i_req_addr_1,
    output i_req_wd_0, i_req_wd_1, i_mem_Rd,
    input  o_req_ready_0, o_req_ready_1, o_rsp_valid_0, o_rsp_valid_1,
    input  o_rsp_rd_0, o_rsp_rd_1, o_mem_Addr, o_mem_Wd, o_mem_Wen, o_mem_Ren
  );

endinterface

// File: rtl/dmem_arbiter_byte_merge.sv
// Combinational byte-lane merge used by the read-modify-write path of dmem_arbiter.
module dmem_byte_merge
  import dmem_arbiter_pkg::*;
(
  input  data_t old_word,
  input  data_t new_word,
  input  be_t   be,
  output data_t merged
);

  // NOTE: the output is given a full default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one operation in flight, byte stores done as read-modify-write.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration (default: port 0 fixed priority).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_RD     = ST_RD;
  localparam logic [2:0] S_WR     = ST_WR;
  localparam logic [2:0] S_RMW_RD = ST_RMW_RD;
  localparam logic [2:0] S_RMW_WR = ST_RMW_WR;
  localparam logic [2:0] S_RESP   = ST_RESP;

  logic [2:0] state_q, state_d;
  logic       rst_q;
  logic       port_q;
  logic       we_q;
  be_t        be_q;
  addr_t      addr_q;
  data_t      wd_q;
  data_t      rd_q;

  logic       idle_ok;
  logic       grant_0, grant_1, accept;
  logic       sel_we;
  be_t        sel_be;
  addr_t      sel_addr;
  data_t      sel_wd;
  data_t      merged_word;
  logic       mem_ren, mem_wen, in_resp;

  // Nothing is granted in the reset cycle nor in the cycle right after it.
  assign idle_ok = (state_q == S_IDLE) && !i_rst && !rst_q;

`ifdef DMEM_ARB_RR_EN
  logic rr_last_q;

  always_comb begin
    grant_0 = idle_ok && bus.i_req_valid_0 && (!bus.i_req_valid_1 ||  rr_last_q);
    grant_1 = idle_ok && bus.i_req_valid_1 && (!bus.i_req_valid_0 || !rr_last_q);
  end

  // Remembers the last granted port; starting at 1 hands the first contention to port 0.
  always_ff @(posedge i_clk) begin
    if (i_rst)       rr_last_q <= 1'b1;
    else if (accept) rr_last_q <= grant_1;
  end
`else
  assign grant_0 = idle_ok && bus.i_req_valid_0;
  assign grant_1 = idle_ok && bus.i_req_valid_1 && !bus.i_req_valid_0;
`endif

  assign accept = grant_0 || grant_1;

  always_comb begin
    sel_we   = bus.i_req_we_0;
    sel_be   = bus.i_req_be_0;
    sel_addr = bus.i_req_addr_0;
    sel_wd   = bus.i_req_wd_0;
    if (grant_1) begin
      sel_we   = bus.i_req_we_1;
      sel_be   = bus.i_req_be_1;
      sel_addr = bus.i_req_addr_1;
      sel_wd   = bus.i_req_wd_1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = accept_state(sel_we, sel_be);
      S_RD:     state_d = S_RESP;
      S_WR:     state_d = S_RESP;
      S_RMW_RD: state_d = S_RMW_WR;
      S_RMW_WR: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the captured request and read data are cleared too, so nothing stale can reach an output after reset.
      state_q <= S_IDLE;
      rst_q   <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      rst_q   <= 1'b0;
      if (accept) begin
        port_q <= grant_1;
        we_q   <= sel_we;
        be_q   <= sel_be;
        addr_q <= sel_addr & WORD_ADDR_MASK;
        wd_q   <= sel_wd;
      end
      if (state_q == S_RD || state_q == S_RMW_RD) rd_q <= bus.i_mem_Rd;
    end
  end

  dmem_byte_merge u_merge (
    .old_word (rd_q),
    .new_word (wd_q),
    .be       (be_q),
    .merged   (merged_word)
  );

  // Enables are gated by reset so an operation aborted mid-write never reaches memory.
  assign mem_ren = !i_rst && (state_q == S_RD || state_q == S_RMW_RD);
  assign mem_wen = !i_rst && ((state_q == S_WR && be_q != 4'h0) || state_q == S_RMW_WR);
  assign in_resp = !i_rst && (state_q == S_RESP);

  assign bus.o_req_ready_0 = grant_0;
  assign bus.o_req_ready_1 = grant_1;

  assign bus.o_mem_Ren  = mem_ren;
  assign bus.o_mem_Wen  = mem_wen;
  assign bus.o_mem_Addr = (mem_ren || mem_wen) ? addr_q : '0;
  assign bus.o_mem_Wd   = !mem_wen ? '0 : (state_q == S_RMW_WR) ? merged_word : wd_q;

  assign bus.o_rsp_valid_0 = in_resp && !port_q;
  assign bus.o_rsp_valid_1 = in_resp &&  port_q;
  assign bus.o_rsp_rd_0    = (in_resp && !port_q && !we_q) ? rd_q : '0;
  assign bus.o_rsp_rd_1    = (in_resp &&  port_q && !we_q) ? rd_q : '0;

endmodule
